// File: rtl/mult_acc_seq.sv
// Channel-serial MAC engine: one K*K*C window per handshake, one channel per cycle
// through K*K multipliers, then bias, optional ReLU and saturation to OUTPUT_WIDTH.
module mult_acc_seq #(
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int KERNEL_SIZE  = 3,
  parameter int IN_CHANNEL   = 3,
  parameter int OUTPUT_WIDTH = 20,
  parameter int BIAS_WIDTH   = 16,
  parameter int SIGNED_MODE  = 0
) (
  input  logic                                                  clk,
  input  logic                                                  rst_n,
  input  logic                                                  weight_valid,
  output logic                                                  weight_ready,
  input  logic [IN_CHANNEL*KERNEL_SIZE*KERNEL_SIZE*WEIGHT_WIDTH-1:0] weight_in,
  input  logic [BIAS_WIDTH-1:0]                                 bias_in,
  input  logic                                                  relu_en,
  input  logic                                                  window_valid,
  output logic                                                  window_ready,
  input  logic [IN_CHANNEL*KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]   window_in,
  output logic                                                  conv_valid,
  input  logic                                                  conv_ready,
  output logic [OUTPUT_WIDTH-1:0]                               conv_out
);

  localparam int KK        = KERNEL_SIZE * KERNEL_SIZE;
  localparam int NE        = IN_CHANNEL * KK;
  localparam int SUM_W     = DATA_WIDTH + WEIGHT_WIDTH + $clog2(NE);
  localparam int ACC_WIDTH = ((SUM_W > BIAS_WIDTH) ? SUM_W : BIAS_WIDTH) + 2;
  localparam int PROD_W    = DATA_WIDTH + WEIGHT_WIDTH + 2;
  localparam int CMP_W     = ((ACC_WIDTH > OUTPUT_WIDTH) ? ACC_WIDTH : OUTPUT_WIDTH) + 2;
  localparam int CNT_W     = (IN_CHANNEL > 1) ? $clog2(IN_CHANNEL) : 1;
  localparam int IDX_W     = (NE > 1) ? $clog2(NE) : 1;
  localparam logic SGN     = (SIGNED_MODE != 0);

  // Clamp bounds held in a width that contains both the accumulator and the output range.
  localparam logic signed [CMP_W-1:0] ONE    = CMP_W'(1);
  localparam logic signed [CMP_W-1:0] SAT_HI = SGN ? ((ONE <<< (OUTPUT_WIDTH-1)) - ONE)
                                                   : ((ONE <<< OUTPUT_WIDTH) - ONE);
  localparam logic signed [CMP_W-1:0] SAT_LO = SGN ? -(ONE <<< (OUTPUT_WIDTH-1)) : '0;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_POST, S_OUT} state_t;

  state_t                        state_q, state_d;
  logic [CNT_W-1:0]              ch_cnt_q, ch_cnt_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [NE*WEIGHT_WIDTH-1:0]    weight_q, weight_d;
  logic [BIAS_WIDTH-1:0]         bias_q, bias_d;
  logic                          relu_q, relu_d;
  logic                          loaded_q, loaded_d;
  logic [NE*DATA_WIDTH-1:0]      window_q, window_d;
  logic                          conv_valid_q, conv_valid_d;
  logic [OUTPUT_WIDTH-1:0]       conv_out_q, conv_out_d;

  logic [WEIGHT_WIDTH-1:0]       w_elem [NE];
  logic [DATA_WIDTH-1:0]         x_elem [NE];
  logic signed [PROD_W-1:0]      prod   [KK];
  logic signed [ACC_WIDTH-1:0]   mac_sum;
  logic signed [ACC_WIDTH-1:0]   bias_ext;
  logic signed [ACC_WIDTH-1:0]   post_sum;
  logic signed [CMP_W-1:0]       post_wide;
  logic [OUTPUT_WIDTH-1:0]       sat_val;
  logic                          win_fire;

  // Weights are packed highest-index-first, windows lowest-index-first.
  generate
    for (genvar gi = 0; gi < NE; gi++) begin : g_unpack
      assign w_elem[gi] = weight_q[(NE-1-gi)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      assign x_elem[gi] = window_q[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // One multiplier per kernel tap; the channel counter selects which slice feeds it.
  generate
    for (genvar gi = 0; gi < KK; gi++) begin : g_lane
      logic [IDX_W-1:0]              idx;
      logic [DATA_WIDTH-1:0]         x_sel;
      logic [WEIGHT_WIDTH-1:0]       w_sel;
      logic signed [DATA_WIDTH:0]    x_ext;
      logic signed [WEIGHT_WIDTH:0]  w_ext;

      assign idx      = IDX_W'(32'(ch_cnt_q) * KK + gi);
      assign x_sel    = x_elem[idx];
      assign w_sel    = w_elem[idx];
      assign x_ext    = $signed({SGN & x_sel[DATA_WIDTH-1], x_sel});
      assign w_ext    = $signed({SGN & w_sel[WEIGHT_WIDTH-1], w_sel});
      assign prod[gi] = x_ext * w_ext;
    end
  endgenerate

  always_comb begin
    mac_sum = '0;
    for (int i = 0; i < KK; i++) begin
      mac_sum = mac_sum + ACC_WIDTH'(prod[i]);
    end
  end

  always_comb begin
    if (SGN) begin
      bias_ext = ACC_WIDTH'($signed(bias_q));
    end else begin
      bias_ext = ACC_WIDTH'(bias_q);
    end
    post_sum = acc_q + bias_ext;
    if (SGN && relu_q && post_sum[ACC_WIDTH-1]) begin
      post_sum = '0;
    end
    post_wide = CMP_W'(post_sum);
    if (post_wide > SAT_HI) begin
      sat_val = SAT_HI[OUTPUT_WIDTH-1:0];
    end else if (post_wide < SAT_LO) begin
      sat_val = SAT_LO[OUTPUT_WIDTH-1:0];
    end else begin
      sat_val = post_wide[OUTPUT_WIDTH-1:0];
    end
  end

  assign weight_ready = (state_q == S_IDLE);
  assign window_ready = loaded_q & ((state_q == S_IDLE) | ((state_q == S_OUT) & conv_ready));
  assign win_fire     = window_valid & window_ready;

  always_comb begin
    state_d      = state_q;
    ch_cnt_d     = ch_cnt_q;
    acc_d        = acc_q;
    weight_d     = weight_q;
    bias_d       = bias_q;
    relu_d       = relu_q;
    loaded_d     = loaded_q;
    window_d     = window_q;
    conv_valid_d = conv_valid_q;
    conv_out_d   = conv_out_q;

    case (state_q)
      S_IDLE: begin
        if (weight_valid) begin
          weight_d = weight_in;
          bias_d   = bias_in;
          relu_d   = relu_en;
          loaded_d = 1'b1;
        end
        if (win_fire) begin
          window_d = window_in;
          acc_d    = '0;
          ch_cnt_d = '0;
          state_d  = S_MAC;
        end
      end
      S_MAC: begin
        acc_d    = acc_q + mac_sum;
        ch_cnt_d = ch_cnt_q + 1'b1;
        if (ch_cnt_q == CNT_W'(IN_CHANNEL-1)) begin
          state_d = S_POST;
        end
      end
      S_POST: begin
        conv_out_d   = sat_val;
        conv_valid_d = 1'b1;
        state_d      = S_OUT;
      end
      S_OUT: begin
        // A window accepted alongside the result drain restarts MAC without an IDLE bubble.
        if (conv_ready) begin
          conv_valid_d = 1'b0;
          if (win_fire) begin
            window_d = window_in;
            acc_d    = '0;
            ch_cnt_d = '0;
            state_d  = S_MAC;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ch_cnt_q     <= '0;
      acc_q        <= '0;
      weight_q     <= '0;
      bias_q       <= '0;
      relu_q       <= 1'b0;
      loaded_q     <= 1'b0;
      window_q     <= '0;
      conv_valid_q <= 1'b0;
      conv_out_q   <= '0;
    end else begin
      state_q      <= state_d;
      ch_cnt_q     <= ch_cnt_d;
      acc_q        <= acc_d;
      weight_q     <= weight_d;
      bias_q       <= bias_d;
      relu_q       <= relu_d;
      loaded_q     <= loaded_d;
      window_q     <= window_d;
      conv_valid_q <= conv_valid_d;
      conv_out_q   <= conv_out_d;
    end
  end

  assign conv_valid = conv_valid_q;
  assign conv_out   = conv_out_q;

endmodule

// File: tb/tb_mult_acc_seq.sv
// Bench for mult_acc_seq: an unsigned and a signed instance share one stimulus stream;
// expected results are queued at each window handshake and checked by per-instance monitors.
module tb_mult_acc_seq;

  localparam int DW = 8;
  localparam int WW = 8;
  localparam int K  = 3;
  localparam int C  = 3;
  localparam int OW = 20;
  localparam int BW = 16;
  localparam int NE = C * K * K;

  typedef struct {
    logic [OW-1:0] u;
    logic [OW-1:0] s;
    int            hs;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              weight_valid = 1'b0;
  logic [NE*WW-1:0]  weight_in = '0;
  logic [BW-1:0]     bias_in = '0;
  logic              relu_en = 1'b0;
  logic              window_valid = 1'b0;
  logic [NE*DW-1:0]  window_in = '0;
  logic              conv_ready;
  logic              cr_drv = 1'b1;
  logic              cr_rand = 1'b1;
  logic              bp_rand = 1'b0;

  logic              weight_ready_w [2];
  logic              window_ready_w [2];
  logic              conv_valid_w   [2];
  logic [OW-1:0]     conv_out_w     [2];

  logic [7:0]        w_s [NE];
  logic [7:0]        w_m [NE];
  logic [7:0]        x_s [NE];
  logic [BW-1:0]     bias_s, bias_m;
  logic              relu_s, relu_m;

  exp_t              exp_q [$];
  int                rd_cnt [2];
  int                checks = 0;
  int                errors = 0;
  int                cyc = 0;

  assign conv_ready = bp_rand ? cr_rand : cr_drv;

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(negedge clk);
    cr_rand = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      mult_acc_seq #(
        .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .KERNEL_SIZE(K), .IN_CHANNEL(C),
        .OUTPUT_WIDTH(OW), .BIAS_WIDTH(BW), .SIGNED_MODE(gi)
      ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .weight_valid (weight_valid),
        .weight_ready (weight_ready_w[gi]),
        .weight_in    (weight_in),
        .bias_in      (bias_in),
        .relu_en      (relu_en),
        .window_valid (window_valid),
        .window_ready (window_ready_w[gi]),
        .window_in    (window_in),
        .conv_valid   (conv_valid_w[gi]),
        .conv_ready   (conv_ready),
        .conv_out     (conv_out_w[gi])
      );

      // Monitor: latency on first sight of a result, value every valid cycle, drain on fire.
      initial begin
        exp_t          e;
        logic [OW-1:0] want;
        bit            seen;
        seen = 0;
        rd_cnt[gi] = 0;
        forever begin
          @(negedge clk);
          #2;
          if (!rst_n) begin
            seen = 0;
          end else if (conv_valid_w[gi]) begin
            if (rd_cnt[gi] >= exp_q.size()) begin
              checks++;
              errors++;
              $display("FAIL unexpected_result dut%0d: conv_valid=1 conv_out=%0h, required no result", gi, conv_out_w[gi]);
            end else begin
              e    = exp_q[rd_cnt[gi]];
              want = (gi == 0) ? e.u : e.s;
              if (!seen) begin
                checks++;
                if (cyc - e.hs != C + 1) begin
                  errors++;
                  $display("FAIL latency dut%0d: %0d cycles, required %0d", gi, cyc - e.hs, C + 1);
                end
                seen = 1;
              end
              checks++;
              if (conv_out_w[gi] !== want) begin
                errors++;
                $display("FAIL conv_out dut%0d: got %0h, required %0h", gi, conv_out_w[gi], want);
              end
              if (conv_ready) begin
                $display("[%0t] dut%0d result #%0d conv_out=%0h", $time, gi, rd_cnt[gi], conv_out_w[gi]);
                rd_cnt[gi]++;
                seen = 0;
              end else begin
                checks++;
                if (window_ready_w[gi] !== 1'b0) begin
                  errors++;
                  $display("FAIL backpressure_ready dut%0d: window_ready=%0b, required 0", gi, window_ready_w[gi]);
                end
              end
            end
          end
        end
      end
    end
  endgenerate

  // Reference: plain integer dot product over all channels, then bias, ReLU and clamp.
  function automatic logic [OW-1:0] model(input bit sgn);
    longint acc, xv, wv, lo, hi;
    acc = 0;
    for (int j = 0; j < NE; j++) begin
      if (sgn) begin
        xv = longint'($signed(x_s[j]));
        wv = longint'($signed(w_m[j]));
      end else begin
        xv = longint'(x_s[j]);
        wv = longint'(w_m[j]);
      end
      acc += xv * wv;
    end
    if (sgn) acc += longint'($signed(bias_m));
    else     acc += longint'(bias_m);
    if (sgn && relu_m && acc < 0) acc = 0;
    if (sgn) begin
      lo = -(longint'(1) <<< (OW - 1));
      hi = (longint'(1) <<< (OW - 1)) - 1;
    end else begin
      lo = 0;
      hi = (longint'(1) <<< OW) - 1;
    end
    if (acc > hi) acc = hi;
    else if (acc < lo) acc = lo;
    return acc[OW-1:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic load_weights();
    bit done;
    done = 0;
    @(negedge clk);
    for (int j = 0; j < NE; j++) weight_in[(NE-1-j)*WW +: WW] = w_s[j];
    bias_in      = bias_s;
    relu_en      = relu_s;
    weight_valid = 1'b1;
    for (int n = 0; n < 300 && !done; n++) begin
      #1;
      if (weight_ready_w[0]) begin
        w_m    = w_s;
        bias_m = bias_s;
        relu_m = relu_s;
        @(posedge clk);
        done = 1;
      end else begin
        @(negedge clk);
      end
    end
    #1 weight_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL weight_load: weight_ready stayed 0, required 1 within budget");
    end
    $display("[%0t] weight load bias=%0h relu=%0b", $time, bias_s, relu_s);
  endtask

  task automatic send_window(input bit keep);
    exp_t e;
    bit   done;
    done = 0;
    @(negedge clk);
    for (int j = 0; j < NE; j++) window_in[j*DW +: DW] = x_s[j];
    window_valid = 1'b1;
    for (int n = 0; n < 300 && !done; n++) begin
      #1;
      if (window_ready_w[0]) begin
        if (keep) begin
          e.u  = model(1'b0);
          e.s  = model(1'b1);
          e.hs = cyc + 1;
          exp_q.push_back(e);
        end
        @(posedge clk);
        done = 1;
      end else begin
        @(negedge clk);
      end
    end
    #1 window_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL window_accept: window_ready stayed 0, required 1 within budget");
    end
    $display("[%0t] window sent keep=%0b", $time, keep);
  endtask

  task automatic drain();
    for (int n = 0; n < 300 && !(rd_cnt[0] == exp_q.size() && rd_cnt[1] == exp_q.size()); n++)
      @(negedge clk);
    @(negedge clk);
    check("drain_dut0", 64'(rd_cnt[0]), 64'(exp_q.size()));
    check("drain_dut1", 64'(rd_cnt[1]), 64'(exp_q.size()));
  endtask

  task automatic fill_w(input logic [7:0] v);
    for (int j = 0; j < NE; j++) w_s[j] = v;
  endtask

  task automatic fill_x(input logic [7:0] v);
    for (int j = 0; j < NE; j++) x_s[j] = v;
  endtask

  initial begin
    bias_s = '0; relu_s = 1'b0; bias_m = '0; relu_m = 1'b0;
    fill_w(8'd0);
    fill_x(8'd0);
    w_m = w_s;

    #1 rst_n = 1'b0;
    #2;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset_conv_valid_dut%0d", i), 64'(conv_valid_w[i]), 64'd0);
      check($sformatf("reset_conv_out_dut%0d", i), 64'(conv_out_w[i]), 64'd0);
      check($sformatf("reset_window_ready_dut%0d", i), 64'(window_ready_w[i]), 64'd0);
      check($sformatf("reset_weight_ready_dut%0d", i), 64'(weight_ready_w[i]), 64'd1);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Basic dot product: 27 * 1 * 2 = 54.
    fill_w(8'd2); bias_s = '0; relu_s = 1'b0;
    load_weights();
    fill_x(8'd1);
    send_window(1'b1);
    drain();
    check("idle_weight_ready", 64'(weight_ready_w[0]), 64'd1);

    // Unsigned saturation; signed sees 27 * (-1)(-1).
    fill_w(8'hFF);
    load_weights();
    fill_x(8'hFF);
    send_window(1'b1);
    drain();

    // Negative result with bias, then ReLU clamp.
    fill_w(8'd3); bias_s = 16'd10; relu_s = 1'b0;
    load_weights();
    fill_x(8'hFF);
    send_window(1'b1);
    drain();
    relu_s = 1'b1;
    load_weights();
    send_window(1'b1);
    drain();

    // Packing order: only weight 13 set, window element j = j+1.
    fill_w(8'd0); w_s[13] = 8'd1; bias_s = '0; relu_s = 1'b0;
    load_weights();
    for (int j = 0; j < NE; j++) x_s[j] = 8'(j + 1);
    send_window(1'b1);
    drain();

    // Backpressure: hold conv_ready low 4 cycles while the next window waits.
    for (int j = 0; j < NE; j++) w_s[j] = 8'($urandom_range(0, 15));
    bias_s = 16'd100;
    load_weights();
    cr_drv = 1'b0;
    for (int j = 0; j < NE; j++) x_s[j] = 8'($urandom);
    send_window(1'b1);
    for (int j = 0; j < NE; j++) x_s[j] = 8'($urandom);
    fork
      send_window(1'b1);
      begin
        for (int n = 0; n < 50 && !conv_valid_w[0]; n++) @(negedge clk);
        repeat (4) @(negedge clk);
        cr_drv = 1'b1;
        #1;
        check("bp_same_cycle_accept", 64'(window_ready_w[0]), 64'd1);
      end
    join
    drain();

    // Reset during the second MAC cycle discards the window and the weights.
    for (int j = 0; j < NE; j++) w_s[j] = 8'($urandom);
    load_weights();
    for (int j = 0; j < NE; j++) x_s[j] = 8'($urandom);
    send_window(1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    fill_w(8'd0); bias_s = '0; relu_s = 1'b0;
    w_m = w_s; bias_m = '0; relu_m = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("midreset_conv_valid_dut%0d", i), 64'(conv_valid_w[i]), 64'd0);
      check($sformatf("midreset_window_ready_dut%0d", i), 64'(window_ready_w[i]), 64'd0);
      check($sformatf("midreset_weight_ready_dut%0d", i), 64'(weight_ready_w[i]), 64'd1);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < NE; j++) window_in[j*DW +: DW] = x_s[j];
    window_valid = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      #1;
      check("noweights_window_ready", 64'(window_ready_w[0]), 64'd0);
      check("noweights_conv_valid", 64'(conv_valid_w[1]), 64'd0);
    end
    window_valid = 1'b0;

    // Randomised traffic with random backpressure and occasional reloads.
    bp_rand = 1'b1;
    for (int it = 0; it < 30; it++) begin
      if (it == 0 || $urandom_range(0, 3) == 0) begin
        for (int j = 0; j < NE; j++) begin
          case ($urandom_range(0, 7))
            0:       w_s[j] = 8'hFF;
            1:       w_s[j] = 8'h80;
            2:       w_s[j] = 8'h7F;
            default: w_s[j] = 8'($urandom);
          endcase
        end
        bias_s = 16'($urandom);
        relu_s = 1'($urandom_range(0, 1));
        load_weights();
      end
      for (int j = 0; j < NE; j++) x_s[j] = 8'($urandom);
      send_window(1'b1);
    end
    bp_rand = 1'b0;
    cr_drv  = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_acc_seq.md
Name: mult_acc_seq

Overview:
- Channel-serial, pipelined multi-channel multiply-accumulate engine. It is the clocked successor of the combinational window MAC in the conv datapath.
- Accepts one K×K×IN_CHANNEL window per handshake and processes one channel per cycle using K*K multipliers.
- Adds a preloaded bias, applies optional ReLU, and saturates to OUTPUT_WIDTH in unsigned or signed mode.
- Sits between the line-buffer/window generator and the output feature-map writer.

Parameters:
- DATA_WIDTH, 8, window element width.
- WEIGHT_WIDTH, 8, weight element width.
- KERNEL_SIZE, 3, kernel side length K.
- IN_CHANNEL, 3, input channels; must be ≥1.
- OUTPUT_WIDTH, 20, result width after saturation.
- BIAS_WIDTH, 16, bias width.
- SIGNED_MODE, 0, 0 = all operands unsigned; 1 = window, weight, bias and result are two's complement.
- ACC_WIDTH (localparam), max(DATA_WIDTH+WEIGHT_WIDTH+$clog2(K*K*IN_CHANNEL), BIAS_WIDTH)+2, accumulator width; never overflows.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- weight_valid  in  1  load request for weights, bias and relu_en.
- weight_ready  out  1  high only in IDLE.
- weight_in  in  IN_CHANNEL*K*K*WEIGHT_WIDTH  packed weights; element j=ch*K*K+i at bits [(IN_CHANNEL*K*K-1-j)*WEIGHT_WIDTH +: WEIGHT_WIDTH] (reversed order).
- bias_in  in  BIAS_WIDTH  bias, loaded with weights.
- relu_en  in  1  ReLU enable, loaded with weights.
- window_valid  in  1  window offered.
- window_ready  out  1  window accepted when valid&ready.
- window_in  in  IN_CHANNEL*K*K*DATA_WIDTH  element j at bits [j*DATA_WIDTH +: DATA_WIDTH].
- conv_valid  out  1  result available.
- conv_ready  in  1  downstream accepts result.
- conv_out  out  OUTPUT_WIDTH  saturated result.

Behaviour:
- Reset (async, any state): state=IDLE, ch_cnt=0, acc=0, weights_loaded=0, conv_valid=0, conv_out=0, window_ready=0, weight_ready=1 (IDLE). Stored weights/bias/relu are cleared to 0. A window in flight is discarded; no output is produced for it.
- FSM states: IDLE, MAC, POST, OUT.
  - IDLE: weight_valid&weight_ready latches weight_in, bias_in and relu_en, and sets weights_loaded.
  - window_ready = weights_loaded & (state==IDLE | (state==OUT & conv_ready)).
  - A window handshake captures window_in into the window buffer, clears acc and ch_cnt, and moves to MAC.
  - If a weight load and a window handshake occur in the same IDLE cycle, that window uses the new weights.
  - MAC: each cycle, acc += sum over i of window[ch_cnt][i]*weight[ch_cnt][i], then ch_cnt++. Extension is zero or sign according to SIGNED_MODE. After the ch_cnt==IN_CHANNEL-1 cycle, move to POST.
  - POST: r = acc + bias (extended to ACC_WIDTH). If relu_en and r<0, r=0. Saturate:
    - unsigned: clamp to [0, 2^OUTPUT_WIDTH-1];
    - signed: clamp to [-2^(OUTPUT_WIDTH-1), 2^(OUTPUT_WIDTH-1)-1].
    - Register into conv_out, set conv_valid, move to OUT.
  - OUT: conv_out/conv_valid held stable until conv_ready.
    - On conv_ready, conv_valid drops, unless a new window is accepted that same cycle. In that case go directly to MAC; conv_valid still drops next cycle.
    - Without a new window, go to IDLE.
- Latency: window handshake at edge T gives MAC edges T+1..T+IN_CHANNEL, POST edge T+IN_CHANNEL+1, and conv_valid high after edge T+IN_CHANNEL+1 (IN_CHANNEL+1 cycles). Throughput is one result per IN_CHANNEL+2 cycles with conv_ready tied high.
- weight_valid outside IDLE is ignored (weight_ready=0). window_valid while weights_loaded=0 is never accepted.
- conv_out holds its last value after conv_valid drops; it is only meaningful when conv_valid=1.
- Unsigned mode: ReLU has no effect. Bias is treated as unsigned.

Test Plan:
- Unsigned, K=3, C=3, bias=0: load weights all 2, window all 1, conv_ready=1 -> conv_out=54, conv_valid rises 4 cycles after the window handshake, one-cycle pulse.
- Saturation, unsigned: window all 255, weights all 255 (sum 1,755,675) -> conv_out=1,048,575.
- SIGNED_MODE=1: window all 8'hFF, weights all 3, bias=+10 -> conv_out=-71 (20'hFFFB9). Reload with relu_en=1 -> conv_out=0.
- Ordering: weight element j=13 only = 1, window element j = j+1 -> conv_out=14. Verifies the reversed weight packing versus forward window packing.
- Backpressure: hold conv_ready=0 for 4 cycles with window_valid=1 -> conv_out stable and window_ready=0. When conv_ready rises, the next window is accepted in that same cycle and the next result follows IN_CHANNEL+1 cycles later.
- Reset mid-MAC: assert rst_n=0 at MAC cycle 2 -> conv_valid=0 immediately, weights_loaded=0, window_ready=0. No result appears after release until weights are reloaded.
